program_loader: RTL and testbench
=================================

# program_loader

Streams a program image, byte by byte, into the CPU's instruction/data memory before execution. It sits directly upstream of the datapath's flash port and drives `flash_en`, `flash_addr` and `flash_data`. While loading, it holds the core via `cpu_hold`; it releases the core once the last word has been written. Input comes from a byte source such as a UART receiver or a JTAG bridge, over a valid/ready handshake.

## Interface
- `WIDTH`, 32, memory word width; fixed at 32 (4 bytes per word)
- `ADDR_WIDTH`, 11, word-address width of the flash port; capacity = 2**ADDR_WIDTH words

- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-low reset
- `start`  in  1  single-cycle request to begin a load
- `byte_valid`  in  1  `byte_data` is valid
- `byte_data`  in  8  incoming image byte
- `byte_ready`  out  1  loader accepts a byte this cycle
- `flash_en`  out  1  one-cycle memory write strobe
- `flash_addr`  out  ADDR_WIDTH  word address of the write
- `flash_data`  out  WIDTH  word to write
- `cpu_hold`  out  1  high keeps the core stalled (PC/IR/regfile writes gated)
- `busy`  out  1  a load is in progress
- `done`  out  1  last load completed successfully (level)
- `error`  out  1  last load header was invalid (level)

## Operation
- Image format: 2-byte little-endian word count N, then 4·N data bytes.
  - Each word is little-endian: first byte → bits [7:0].
- Valid N: 1 ≤ N ≤ 2**ADDR_WIDTH.
- Words are written to addresses 0 … N-1 in order.
- A byte transfers only on `byte_valid && byte_ready`.
- States:
  - IDLE: ready=0.
    - `start` → HDR_LO.
  - HDR_LO: ready=1.
    - Accept → latch N[7:0] → HDR_HI.
  - HDR_HI: ready=1.
    - Accept → latch N[15:8].
    - Next state is ERR if the full N is invalid, else DATA with word index 0 and byte count 0.
  - DATA: ready=1.
    - Each accepted byte shifts into the assembler.
    - The 4th accepted byte → WRITE.
  - WRITE: ready=0.
    - `flash_en`=1, `flash_addr`=index, `flash_data`=assembled word.
    - If index == N-1 → DONE; else index+1 → DATA.
  - DONE: `done`=1, `cpu_hold`=0.
    - `start` → HDR_LO; this clears `done` and reasserts `cpu_hold`.
  - ERR: `error`=1, `cpu_hold`=1.
    - `start` → HDR_LO; this clears `error`.
- `busy` = state ∈ {HDR_LO, HDR_HI, DATA, WRITE}.
- `start` is ignored while `busy`.
- `cpu_hold` = 1 in every state except DONE.
- `flash_addr`/`flash_data` are don't-care when `flash_en`=0; they are held at their last values.
- The index counter is ADDR_WIDTH+1 bits wide to cover N = 2**ADDR_WIDTH.
  - `flash_addr` is its low ADDR_WIDTH bits.
  - It never wraps within a legal load.

## Timing
- Reset (`rst`=0 at a clock edge) → IDLE next cycle, with these output values:
  - `byte_ready`=0, `flash_en`=0, `flash_addr`=0, `flash_data`=0
  - `cpu_hold`=1, `busy`=0, `done`=0, `error`=0
  - index=0, byte count=0
- Reset mid-load aborts immediately: no further `flash_en`, and partial words are discarded.
- Reset dominates `start` and byte handshakes in the same cycle.
- `start` in IDLE: `byte_ready` rises the following cycle.
  - A `byte_valid` in the same cycle as `start` is not consumed.
- Latency: `flash_en` is asserted the cycle after the 4th byte of a word is accepted.
- Per-word throughput: 4 byte cycles + 1 WRITE cycle, i.e. 5 cycles minimum.
- After the final WRITE, `done`=1 and `cpu_hold`=0 in the next cycle.
- `byte_valid` may stall at any point; the loader waits indefinitely with no timeout.
- `byte_data` is sampled only on the accepting edge.
- Exactly one `flash_en` pulse per word; never two consecutive cycles.

## Structure
- Shared package `loader_pkg`:
  - `loader_state_t` enum (IDLE, HDR_LO, HDR_HI, DATA, WRITE, DONE, ERR)
  - `BYTES_PER_WORD` = 4
  - header field width constant = 16
- Sub-module `byte_assembler`:
  - 32-bit shift register with a 2-bit byte counter.
  - Inputs: load strobe, byte, clear.
  - Outputs: word, `word_full`.
  - Its reset is synchronous active-low, same as the parent.
- `program_loader` itself holds the FSM, the N register, the index counter and the output registers.
- All outputs are registered or decoded directly from state.

## Test plan
- Reset, then `start`; image N=2, bytes 02 00 | 78 56 34 12 | EF BE AD DE.
  - Exactly two `flash_en` pulses: addr 0 with 0x12345678, addr 1 with 0xDEADBEEF.
  - Then `done`=1, `cpu_hold`=0.
- Header 00 00 → `error`=1, `cpu_hold`=1, no `flash_en`.
- Header 01 08 (N=2049 > 2048) → `error`=1.
  - A following `start` with a valid N=1 image clears `error` and writes addr 0.
- Random `byte_valid` gaps (0–5 idle cycles) during an N=3 image → identical writes and addresses to the gap-free run.
  - `byte_ready` is 0 on every WRITE cycle.
- `rst`=0 after 6 data bytes of an N=4 image:
  - next cycle all outputs are at reset values;
  - `flash_en` never pulses for word 1;
  - a fresh load then works from addr 0.
- N=2048 full image → last write to addr 0x7FF, no wrap to 0.
  - `start` asserted during the load is ignored.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader and its byte assembler.
package loader_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned HDR_WIDTH      = 16;

    typedef enum logic [2:0] {
        StIdle,
        StHdrLo,
        StHdrHi,
        StData,
        StWrite,
        StDone,
        StErr
    } loader_state_t;

endpackage

// File: rtl/byte_assembler.sv
// Packs little-endian bytes into a word; word_o shows the word including the byte being loaded.
module byte_assembler
    import loader_pkg::*;
#(
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [7:0]       byte_i,
    input  logic             clear_i,
    output logic [Width-1:0] word_o,
    output logic             word_full_o
);

    logic [Width-1:0] word_q, word_d;
    logic [1:0]       cnt_q, cnt_d;

    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            // First byte ends up in [7:0] after four shifts.
            word_d = {byte_i, word_q[Width-1:8]};
            cnt_d  = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

    assign word_o      = word_d;
    assign word_full_o = load_i && !clear_i && (cnt_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/program_loader.sv
// Streams a length-prefixed byte image into instruction memory while holding the core.
module program_loader
    import loader_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH = 11
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  byte_valid_i,
    input  logic [7:0]            byte_data_i,
    output logic                  byte_ready_o,
    output logic                  flash_en_o,
    output logic [ADDR_WIDTH-1:0] flash_addr_o,
    output logic [WIDTH-1:0]      flash_data_o,
    output logic                  cpu_hold_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o
);

    localparam int unsigned IdxW = ADDR_WIDTH + 1;

    loader_state_t         state_q, state_d;
    logic [HDR_WIDTH-1:0]  n_q, n_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] flash_addr_q, flash_addr_d;
    logic [WIDTH-1:0]      flash_data_q, flash_data_d;

    logic                  accept;
    logic [HDR_WIDTH-1:0]  n_full;
    logic                  n_ok;
    logic                  last_word;
    logic                  asm_load, asm_clear, asm_full;
    logic [WIDTH-1:0]      asm_word;

    assign byte_ready_o = (state_q == StHdrLo) || (state_q == StHdrHi) || (state_q == StData);
    assign accept       = byte_valid_i && byte_ready_o;
    assign n_full       = {byte_data_i, n_q[7:0]};
    assign n_ok         = (n_full != '0) && (32'(n_full) <= (32'd1 << ADDR_WIDTH));
    assign last_word    = (HDR_WIDTH'(idx_q) == (n_q - HDR_WIDTH'(1)));
    assign asm_load     = (state_q == StData) && accept;
    assign asm_clear    = (state_q == StHdrHi) && accept;

    byte_assembler #(
        .Width(WIDTH)
    ) u_byte_assembler (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (asm_load),
        .byte_i     (byte_data_i),
        .clear_i    (asm_clear),
        .word_o     (asm_word),
        .word_full_o(asm_full)
    );

    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        idx_d        = idx_q;
        flash_addr_d = flash_addr_q;
        flash_data_d = flash_data_q;
        case (state_q)
            StIdle, StDone, StErr: begin
                if (start_i) state_d = StHdrLo;
            end
            StHdrLo: begin
                if (accept) begin
                    n_d[7:0] = byte_data_i;
                    state_d  = StHdrHi;
                end
            end
            StHdrHi: begin
                if (accept) begin
                    n_d[15:8] = byte_data_i;
                    idx_d     = '0;
                    state_d   = n_ok ? StData : StErr;
                end
            end
            StData: begin
                if (asm_full) begin
                    flash_addr_d = idx_q[ADDR_WIDTH-1:0];
                    flash_data_d = asm_word;
                    state_d      = StWrite;
                end
            end
            StWrite: begin
                if (last_word) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + IdxW'(1);
                    state_d = StData;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            n_q          <= '0;
            idx_q        <= '0;
            flash_addr_q <= '0;
            flash_data_q <= '0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            idx_q        <= idx_d;
            flash_addr_q <= flash_addr_d;
            flash_data_q <= flash_data_d;
        end
    end

    assign flash_en_o   = (state_q == StWrite);
    assign flash_addr_o = flash_addr_q;
    assign flash_data_o = flash_data_q;
    assign cpu_hold_o   = (state_q != StDone);
    assign busy_o       = byte_ready_o || (state_q == StWrite);
    assign done_o       = (state_q == StDone);
    assign error_o      = (state_q == StErr);

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: table of images plus reset, start-overlap and full-size cases.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        bv = 1'b0;
    logic [7:0]  bd = 8'h00;
    logic        byte_ready, flash_en, cpu_hold, busy, done, error;
    logic [10:0] flash_addr;
    logic [31:0] flash_data;

    program_loader #(
        .WIDTH     (32),
        .ADDR_WIDTH(11)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .byte_valid_i(bv),
        .byte_data_i (bd),
        .byte_ready_o(byte_ready),
        .flash_en_o  (flash_en),
        .flash_addr_o(flash_addr),
        .flash_data_o(flash_data),
        .cpu_hold_o  (cpu_hold),
        .busy_o      (busy),
        .done_o      (done),
        .error_o     (error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [10:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [31:0] exp_q[$];
    logic        prev_en = 1'b0;

    // Capture every write; a write must never overlap byte_ready or follow another write.
    always @(negedge clk) begin
        if (flash_en) begin
            wr_addr_q.push_back(flash_addr);
            wr_data_q.push_back(flash_data);
            checks++;
            if (byte_ready !== 1'b0 || prev_en) begin
                errors++;
                $display("FAIL write_strobe actual ready=%0b prev_en=%0b required ready=0 prev_en=0",
                         byte_ready, prev_en);
            end
        end
        prev_en <= flash_en;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(byte_ready), 32'd0);
        chk({tag, "_en"}, 32'(flash_en), 32'd0);
        chk({tag, "_addr"}, 32'(flash_addr), 32'd0);
        chk({tag, "_data"}, flash_data, 32'd0);
        chk({tag, "_hold"}, 32'(cpu_hold), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        bv = 1'b1;
        bd = b;
        waited = 0;
        while (1) begin
            @(negedge clk);
            if (byte_ready) begin
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
            waited++;
            if (waited > 50) begin
                checks++;
                errors++;
                $display("FAIL byte_accept_timeout actual=not_ready required=ready");
                break;
            end
        end
        bv = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap_max);
        for (int k = 0; k < 4; k++) begin
            logic [31:0] tmp;
            tmp = w >> (8 * k);
            send_byte(tmp[7:0], (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0);
        end
        exp_q.push_back(w);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_end(input string name);
        int i;
        for (i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || error) break;
        end
        if (i == 40) begin
            checks++;
            errors++;
            $display("FAIL %s_end_timeout actual=busy required=done_or_error", name);
        end
    endtask

    task automatic check_writes(input string name, input int n);
        int bad;
        bad = -1;
        checks++;
        if (wr_addr_q.size() != n || exp_q.size() != n) begin
            errors++;
            $display("FAIL %s_count actual=%0d writes required=%0d", name, wr_addr_q.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                if (bad < 0 && (wr_addr_q[i] !== 11'(i) || wr_data_q[i] !== exp_q[i])) bad = i;
            end
            if (bad >= 0) begin
                errors++;
                $display("FAIL %s_write%0d actual=%h@%h required=%h@%h", name, bad,
                         wr_data_q[bad], wr_addr_q[bad], exp_q[bad], 11'(bad));
            end
        end
        wr_addr_q.delete();
        wr_data_q.delete();
        exp_q.delete();
    endtask

    typedef struct {
        logic [7:0]       lo;
        logic [7:0]       hi;
        logic             exp_err;
        int               gap_max;
        logic [2:0][31:0] w;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{lo: 8'h02, hi: 8'h00, exp_err: 1'b0, gap_max: 0,
                    w: {32'h0, 32'hDEADBEEF, 32'h12345678}};
        vecs[1] = '{lo: 8'h00, hi: 8'h00, exp_err: 1'b1, gap_max: 0, w: '0};
        vecs[2] = '{lo: 8'h01, hi: 8'h08, exp_err: 1'b1, gap_max: 0, w: '0};
        vecs[3] = '{lo: 8'h01, hi: 8'h00, exp_err: 1'b0, gap_max: 0,
                    w: {32'h0, 32'h0, 32'hCAFEF00D}};
        vecs[4] = '{lo: 8'h03, hi: 8'h00, exp_err: 1'b0, gap_max: 5,
                    w: {32'h0BADC0DE, 32'h89ABCDEF, 32'h01234567}};
        vecs[5] = '{lo: 8'h03, hi: 8'h00, exp_err: 1'b0, gap_max: 0,
                    w: {32'h0BADC0DE, 32'h89ABCDEF, 32'h01234567}};

        // Reset must dominate start and a valid byte in the same cycles.
        start = 1'b1;
        bv    = 1'b1;
        bd    = 8'h33;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        bv    = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int v = 0; v < 6; v++) begin
            int n;
            string name;
            name = $sformatf("vec%0d", v);
            n = int'({vecs[v].hi, vecs[v].lo});
            pulse_start();
            @(negedge clk);
            chk({name, "_start_ready"}, 32'(byte_ready), 32'd1);
            chk({name, "_start_flags"}, {30'd0, error, done}, 32'd0);
            @(posedge clk);
            #1;
            send_byte(vecs[v].lo, vecs[v].gap_max);
            send_byte(vecs[v].hi, vecs[v].gap_max);
            if (!vecs[v].exp_err) begin
                for (int j = 0; j < n; j++) send_word(vecs[v].w[j], vecs[v].gap_max);
            end
            wait_end(name);
            chk({name, "_error"}, 32'(error), 32'(vecs[v].exp_err));
            chk({name, "_done"}, 32'(done), 32'(!vecs[v].exp_err));
            chk({name, "_hold"}, 32'(cpu_hold), 32'(vecs[v].exp_err));
            chk({name, "_busy"}, 32'(busy), 32'd0);
            check_writes(name, vecs[v].exp_err ? 0 : n);
            @(posedge clk);
            #1;
        end

        // A byte offered in the start cycle is not consumed.
        start = 1'b1;
        bv    = 1'b1;
        bd    = 8'h07;
        @(posedge clk);
        #1;
        start = 1'b0;
        bv    = 1'b0;
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_word(32'hA1B2C3D4, 0);
        wait_end("overlap");
        chk("overlap_done", 32'(done), 32'd1);
        check_writes("overlap", 1);
        @(posedge clk);
        #1;

        // Reset after six data bytes of an N=4 image.
        pulse_start();
        send_byte(8'h04, 0);
        send_byte(8'h00, 0);
        send_word(32'h11223344, 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_outputs("abort");
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check_writes("abort", 1);
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_word(32'h76543210, 0);
        wait_end("fresh");
        chk("fresh_done", 32'(done), 32'd1);
        check_writes("fresh", 1);
        @(posedge clk);
        #1;

        // Full-capacity image with a stray start mid-load.
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h08, 0);
        for (int i = 0; i < 2048; i++) begin
            logic [15:0] iv;
            iv = 16'(i);
            if (i == 100) pulse_start();
            send_word({iv, ~iv} ^ 32'h13579BDF, 0);
        end
        wait_end("full");
        chk("full_done", 32'(done), 32'd1);
        chk("full_hold", 32'(cpu_hold), 32'd0);
        chk("full_last_addr", 32'(flash_addr), 32'h7FF);
        check_writes("full", 2048);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
